// File: rtl/aes_selftest_ctrl.sv
// Self-test sequencer for the round-per-cycle AES Cipher/InvCipher cores.
// Runs encrypt and/or decrypt passes, checks results, and shows one state byte as BCD.
module aes_selftest_ctrl #(
  parameter int NK       = 4,
  parameter int NR       = NK + 6,
  parameter int MODE     = 2,
  parameter int BYTE_SEL = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         auto_repeat,
  input  logic [0:127] plaintext,
  input  logic [0:127] expected_ct,
  input  logic [0:127] ct_in,
  input  logic [0:127] pt_in,
  output logic         cipher_en,
  output logic         inv_en,
  output logic [4:0]   round_num,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic         fail,
  output logic [3:0]   units,
  output logic [3:0]   tens,
  output logic [3:0]   hunds
);

  typedef enum logic [2:0] {IDLE, ENC, ENC_CHK, DEC, DEC_CHK, DONE} state_t;

  localparam logic [4:0] LAST_ROUND = 5'(NR);
  localparam bit         DO_ENC     = (MODE != 1);
  localparam bit         DO_DEC     = (MODE != 0);
  localparam state_t     FIRST_PASS = DO_ENC ? ENC : DEC;

  state_t       state_q, state_d;
  logic [4:0]   round_q, round_d;
  logic         cipher_en_q, cipher_en_d;
  logic         inv_en_q, inv_en_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic         fail_q, fail_d;
  logic         enc_ok_q, enc_ok_d;
  logic         ran_q, ran_d;
  logic [0:127] disp_q, disp_d;

  logic ct_match, pt_match, dec_verdict;

  assign ct_match    = (ct_in == expected_ct);
  assign pt_match    = (pt_in == plaintext);
  assign dec_verdict = pt_match & (DO_ENC ? enc_ok_q : 1'b1);

  // Next-state logic; every output register is derived from the next state so
  // enables, busy and done line up with the state they describe.
  always_comb begin
    state_d  = state_q;
    round_d  = round_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    enc_ok_d = enc_ok_q;
    ran_d    = ran_q;
    disp_d   = disp_q;

    case (state_q)
      IDLE: begin
        if (!ran_q) disp_d = plaintext;
        if (start) begin
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          enc_ok_d = 1'b0;
          ran_d    = 1'b1;
          round_d  = 5'd0;
          state_d  = FIRST_PASS;
        end
      end
      ENC: begin
        disp_d = ct_in;
        if (round_q == LAST_ROUND) begin
          round_d = 5'd0;
          state_d = ENC_CHK;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      ENC_CHK: begin
        disp_d   = ct_in;
        enc_ok_d = ct_match;
        if (DO_DEC) begin
          round_d = 5'd0;
          state_d = DEC;
        end else begin
          pass_d  = ct_match;
          fail_d  = !ct_match;
          state_d = DONE;
        end
      end
      DEC: begin
        disp_d = pt_in;
        if (round_q == LAST_ROUND) begin
          round_d = 5'd0;
          state_d = DEC_CHK;
        end else begin
          round_d = round_q + 5'd1;
        end
      end
      DEC_CHK: begin
        disp_d  = pt_in;
        pass_d  = dec_verdict;
        fail_d  = !dec_verdict;
        state_d = DONE;
      end
      DONE: begin
        if (auto_repeat) begin
          pass_d   = 1'b0;
          fail_d   = 1'b0;
          enc_ok_d = 1'b0;
          round_d  = 5'd0;
          state_d  = FIRST_PASS;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    cipher_en_d = (state_d == ENC);
    inv_en_d    = (state_d == DEC);
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      round_q     <= 5'd0;
      cipher_en_q <= 1'b0;
      inv_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      enc_ok_q    <= 1'b0;
      ran_q       <= 1'b0;
      disp_q      <= plaintext;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      cipher_en_q <= cipher_en_d;
      inv_en_q    <= inv_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_q      <= fail_d;
      enc_ok_q    <= enc_ok_d;
      ran_q       <= ran_d;
      disp_q      <= disp_d;
    end
  end

  assign cipher_en = cipher_en_q;
  assign inv_en    = inv_en_q;
  assign round_num = round_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;

  // Byte BYTE_SEL of the big-endian vector; the lowest index is its MSB.
  logic [7:0] sel_byte, rem;
  assign sel_byte = disp_q[8*BYTE_SEL +: 8];

  always_comb begin
    rem   = sel_byte;
    hunds = 4'd0;
    if (sel_byte >= 8'd200) begin
      hunds = 4'd2;
      rem   = sel_byte - 8'd200;
    end else if (sel_byte >= 8'd100) begin
      hunds = 4'd1;
      rem   = sel_byte - 8'd100;
    end
    tens  = 4'(rem / 8'd10);
    units = 4'(rem % 8'd10);
  end

endmodule

// File: tb/tb_aes_selftest_ctrl.sv
// Bench for aes_selftest_ctrl: an NK=4/MODE=2 instance and an NK=8/MODE=0 instance,
// each driven by a small stand-in core model, with done-time/verdict scoreboards.
module tb_aes_selftest_ctrl;

  localparam logic [0:127] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [0:127] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [0:127] FIPS_CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [0:127] plaintext = FIPS_PT;

  logic         start_a = 1'b0, auto_a = 1'b0;
  logic [0:127] exp_ct_a = FIPS_CT;
  logic [0:127] ct_a = '0, pt_a = '0;
  logic         cipher_en_a, inv_en_a, busy_a, done_a, pass_a, fail_a;
  logic [4:0]   round_num_a;
  logic [3:0]   units_a, tens_a, hunds_a;

  logic         start_b = 1'b0, auto_b = 1'b0;
  logic [0:127] exp_ct_b = FIPS_CT8;
  logic [0:127] ct_b = '0;
  logic [0:127] pt_b = '0;
  logic         cipher_en_b, inv_en_b, busy_b, done_b, pass_b, fail_b;
  logic [4:0]   round_num_b;
  logic [3:0]   units_b, tens_b, hunds_b;

  aes_selftest_ctrl #(.NK(4), .MODE(2), .BYTE_SEL(15)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .auto_repeat(auto_a),
    .plaintext(plaintext), .expected_ct(exp_ct_a), .ct_in(ct_a), .pt_in(pt_a),
    .cipher_en(cipher_en_a), .inv_en(inv_en_a), .round_num(round_num_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .fail(fail_a),
    .units(units_a), .tens(tens_a), .hunds(hunds_a)
  );

  aes_selftest_ctrl #(.NK(8), .MODE(0), .BYTE_SEL(7)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .auto_repeat(auto_b),
    .plaintext(plaintext), .expected_ct(exp_ct_b), .ct_in(ct_b), .pt_in(pt_b),
    .cipher_en(cipher_en_b), .inv_en(inv_en_b), .round_num(round_num_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .fail(fail_b),
    .units(units_b), .tens(tens_b), .hunds(hunds_b)
  );

  // Stand-in cores: intermediate rounds leave a round-tagged pattern, the last
  // round produces the known result (decrypt only recovers the plaintext from a good ciphertext).
  function automatic logic [0:127] junk(input logic [4:0] r);
    logic [7:0] b;
    b = {r, 3'b101};
    return {16{b}};
  endfunction

  always @(posedge clk) begin
    if (cipher_en_a) ct_a <= (round_num_a == 5'd10) ? FIPS_CT : junk(round_num_a);
    if (inv_en_a)    pt_a <= (round_num_a == 5'd10) ? ((ct_a == FIPS_CT) ? FIPS_PT : ~FIPS_PT)
                                                    : junk(round_num_a);
    if (cipher_en_b) ct_b <= (round_num_b == 5'd14) ? FIPS_CT8 : junk(round_num_b);
  end

  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  typedef struct {
    int cyc;
    bit pass;
  } sb_t;

  sb_t sb_a[$];
  int  sb_b[$];
  bit  mon_en = 1'b0;
  int  exp_round_b = 0;

  // Scoreboard monitors: every done must match a queued expectation.
  always @(negedge clk) begin
    sb_t e;
    if (mon_en) begin
      checkOutput("a_enables_exclusive", {31'd0, cipher_en_a & inv_en_a}, 32'd0);
      if (done_a) begin
        if (sb_a.size() == 0) begin
          checkOutput("a_unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_a.pop_front();
          checkOutput("a_done_cycle", cyc, e.cyc);
          checkOutput("a_pass", {31'd0, pass_a}, {31'd0, e.pass});
          checkOutput("a_fail", {31'd0, fail_a}, {31'd0, !e.pass});
        end
      end
    end
  end

  always @(negedge clk) begin
    int c;
    if (mon_en) begin
      checkOutput("b_inv_never", {31'd0, inv_en_b}, 32'd0);
      if (cipher_en_b) begin
        checkOutput("b_round", {27'd0, round_num_b}, exp_round_b);
        exp_round_b++;
      end
      if (done_b) begin
        checkOutput("b_enc_cycles", exp_round_b, 32'd15);
        exp_round_b = 0;
        if (sb_b.size() == 0) begin
          checkOutput("b_unexpected_done", 32'd1, 32'd0);
        end else begin
          c = sb_b.pop_front();
          checkOutput("b_done_cycle", cyc, c);
        end
      end
    end
  end

  typedef struct {
    string name;
    bit    flip_ct;
    bit    flip_pt;
    bit    hold_start;
    bit    exp_pass;
  } vec_t;

  vec_t vecs[4];
  bit   hold_active = 1'b0;

  // Starts one run on instance A; returns in the first cycle of the run.
  task automatic applyStimulus(input vec_t v);
    sb_t e;
    @(negedge clk);
    exp_ct_a  = v.flip_ct ? (FIPS_CT ^ 128'h1) : FIPS_CT;
    plaintext = v.flip_pt ? (FIPS_PT ^ 128'h1) : FIPS_PT;
    start_a   = 1'b1;
    e.cyc     = cyc + 25;
    e.pass    = v.exp_pass;
    sb_a.push_back(e);
    @(negedge clk);
    hold_active = v.hold_start;
    if (!v.hold_start) start_a = 1'b0;
    checkOutput({v.name, "_start_clears"}, {30'd0, pass_a, fail_a}, 32'd0);
    checkOutput({v.name, "_first_cycle"}, {25'd0, busy_a, cipher_en_a, round_num_a}, {25'd0, 2'b11, 5'd0});
  endtask

  task automatic waitDone(input bit use_b, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if ((use_b ? done_b : done_a) === 1'b1) ok = 1'b1;
    end
    if (!ok) checkOutput(use_b ? "b_done_timeout" : "a_done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    int got;
    bit busy_low, prev_done;

    vecs[0] = '{name: "good",       flip_ct: 1'b0, flip_pt: 1'b0, hold_start: 1'b0, exp_pass: 1'b1};
    vecs[1] = '{name: "bad_ct",     flip_ct: 1'b1, flip_pt: 1'b0, hold_start: 1'b0, exp_pass: 1'b0};
    vecs[2] = '{name: "bad_pt",     flip_ct: 1'b0, flip_pt: 1'b1, hold_start: 1'b0, exp_pass: 1'b0};
    vecs[3] = '{name: "hold_start", flip_ct: 1'b0, flip_pt: 1'b0, hold_start: 1'b1, exp_pass: 1'b1};

    repeat (3) @(negedge clk);
    checkOutput("reset_a_outputs", {24'd0, cipher_en_a, inv_en_a, busy_a, done_a, pass_a, fail_a, 2'b00},
                32'd0);
    checkOutput("reset_a_round", {27'd0, round_num_a}, 32'd0);
    checkOutput("reset_a_digits", {20'd0, hunds_a, tens_a, units_a}, 32'h255);
    checkOutput("reset_b_digits", {20'd0, hunds_b, tens_b, units_b}, 32'h119);
    reset = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_start", {31'd0, busy_a}, 32'd0);

    // Abort mid-encrypt and confirm a clean return to IDLE with plaintext reloaded.
    applyStimulus(vecs[0]);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cipher_en_a && round_num_a == 5'd5) ok = 1'b1;
      else @(negedge clk);
    end
    checkOutput("abort_reached_round5", {31'd0, ok}, 32'd1);
    checkOutput("mid_enc_digits", {20'd0, hunds_a, tens_a, units_a}, 32'h029);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb_a.delete();
    checkOutput("abort_outputs", {24'd0, cipher_en_a, inv_en_a, busy_a, done_a, pass_a, fail_a, 2'b00},
                32'd0);
    checkOutput("abort_round", {27'd0, round_num_a}, 32'd0);
    checkOutput("abort_digits", {20'd0, hunds_a, tens_a, units_a}, 32'h255);
    @(negedge clk);
    checkOutput("abort_stays_idle", {31'd0, busy_a}, 32'd0);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(vecs[k]);
      waitDone(1'b0, 60, ok);
      if (hold_active) start_a = 1'b0;
      checkOutput({vecs[k].name, "_final_digits"}, {20'd0, hunds_a, tens_a, units_a}, 32'h255);
      @(negedge clk);
      checkOutput({vecs[k].name, "_done_one_cycle"}, {31'd0, done_a}, 32'd0);
      repeat (3) @(negedge clk);
      checkOutput({vecs[k].name, "_verdict_held"}, {29'd0, busy_a, pass_a, fail_a},
                  {29'd0, 1'b0, vecs[k].exp_pass, !vecs[k].exp_pass});
    end
    plaintext = FIPS_PT;
    exp_ct_a  = FIPS_CT;

    // Back-to-back runs: done every 25 cycles, busy never drops, pass cleared on re-entry.
    @(negedge clk);
    auto_a  = 1'b1;
    start_a = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      sb_t e;
      e.cyc  = cyc + 25 * r;
      e.pass = 1'b1;
      sb_a.push_back(e);
    end
    @(negedge clk);
    start_a   = 1'b0;
    got       = 0;
    busy_low  = 1'b0;
    prev_done = 1'b0;
    for (int i = 0; i < 100 && got < 3; i++) begin
      @(negedge clk);
      if (!busy_a) busy_low = 1'b1;
      if (prev_done) begin
        checkOutput("auto_pass_cleared", {30'd0, pass_a, fail_a}, 32'd0);
        checkOutput("auto_round0", {26'd0, cipher_en_a, round_num_a}, {26'd0, 1'b1, 5'd0});
      end
      prev_done = done_a;
      if (done_a) begin
        got++;
        if (got == 3) auto_a = 1'b0;
      end
    end
    checkOutput("auto_done_count", got, 32'd3);
    checkOutput("auto_busy_stayed", {31'd0, busy_low}, 32'd0);
    @(negedge clk);
    checkOutput("auto_back_to_idle", {31'd0, busy_a}, 32'd0);

    // Encrypt-only AES-256 instance.
    @(negedge clk);
    start_b = 1'b1;
    sb_b.push_back(cyc + 17);
    @(negedge clk);
    start_b = 1'b0;
    waitDone(1'b1, 40, ok);
    checkOutput("b_verdict", {30'd0, pass_b, fail_b}, {30'd0, 2'b10});
    checkOutput("b_final_digits", {20'd0, hunds_b, tens_b, units_b}, 32'h191);
    repeat (3) @(negedge clk);
    checkOutput("b_idle_after", {31'd0, busy_b}, 32'd0);

    repeat (30) @(negedge clk);
    checkOutput("a_scoreboard_empty", sb_a.size(), 32'd0);
    checkOutput("b_scoreboard_empty", sb_b.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
